// File: rtl/capi_pkg.sv
// Shared PSL job-interface definitions: controller states, job command codes
// and the error-word bit positions reported on ah_jerror.
package capi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RESETTING = 2'd1,
    ST_DONE      = 2'd2,
    ST_RUNNING   = 2'd3
  } job_state_e;

  localparam logic [7:0] CMD_RESET = 8'h80;
  localparam logic [7:0] CMD_START = 8'h90;
  localparam logic [7:0] CMD_LLCMD = 8'h45;

  // Bit indices use the PSL big-endian numbering of a [0:63] word.
  localparam int ERR_BIT_INVALID = 61;
  localparam int ERR_BIT_START   = 62;
  localparam int ERR_BIT_PARITY  = 63;

  function automatic logic odd_parity_ok(input logic [7:0] com, input logic par);
    return ^{com, par};
  endfunction

endpackage

// File: rtl/job_reset_counter.sv
// 8-bit down-counter that times the core_reset window of a job reset.
module job_reset_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/job_controller.sv
// PSL job controller: decodes job commands, sequences core reset/start/done
// and reports the accumulated error word with ah_jdone.
module job_controller
  import capi_pkg::*;
#(
  parameter int RESET_CYCLES = 16
) (
  input  logic        ha_pclock,
  input  logic        ha_preset_n,
  input  logic        ha_jval,
  input  logic [0:7]  ha_jcom,
  input  logic        ha_jcompar,
  input  logic [0:63] ha_jea,
  input  logic        parity_en,
  input  logic        core_done,
  input  logic [0:63] core_error,
  output logic        core_reset,
  output logic        core_start,
  output logic [0:63] job_ea,
  output logic        ah_jrunning,
  output logic        ah_jdone,
  output logic        ah_jcack,
  output logic [0:63] ah_jerror,
  output logic        ah_jyield
);

  localparam logic [7:0] RESET_LOAD = 8'(RESET_CYCLES - 1);

  job_state_e  state_q, state_d;
  logic [0:63] pending_q, pending_d;
  logic [0:63] job_ea_q, job_ea_d;
  logic        core_reset_q, core_reset_d;
  logic        core_start_q, core_start_d;
  logic        jcack_q, jcack_d;
  logic        llpend_q, llpend_d;

  logic par_err, cmd_ok;
  logic is_reset, is_start, is_llcmd, is_invalid;
  logic cnt_load, cnt_dec, cnt_zero;
  logic ll_now, ll_defer, done_exit;

  // Command decode; a parity failure suppresses the command entirely.
  always_comb begin
    par_err    = ha_jval && parity_en && !odd_parity_ok(ha_jcom, ha_jcompar);
    cmd_ok     = ha_jval && !par_err;
    is_reset   = cmd_ok && (ha_jcom == CMD_RESET);
    is_start   = cmd_ok && (ha_jcom == CMD_START);
    is_llcmd   = cmd_ok && (ha_jcom == CMD_LLCMD);
    is_invalid = cmd_ok && !is_reset && !is_start && !is_llcmd;
  end

  job_reset_counter u_reset_counter (
    .clk      (ha_pclock),
    .rst_n    (ha_preset_n),
    .load     (cnt_load),
    .load_val (RESET_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
    if (!ha_preset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; RESET outranks everything except an ongoing RESETTING.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_reset) begin
          state_d  = ST_RESETTING;
          cnt_load = 1'b1;
        end else if (is_start) begin
          state_d = ST_RUNNING;
        end
      end
      ST_RESETTING: begin
        if (cnt_zero) begin
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        if (is_reset) begin
          state_d  = ST_RESETTING;
          cnt_load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUNNING: begin
        if (is_reset) begin
          state_d  = ST_RESETTING;
          cnt_load = 1'b1;
        end else if (core_done) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs and datapath next values
  always_comb begin
    pending_d = (state_q == ST_DONE) ? '0 : pending_q;
    if ((state_q == ST_RUNNING) && core_done && !is_reset) begin
      pending_d = pending_d | core_error;
    end
    if (par_err) begin
      pending_d[ERR_BIT_PARITY] = 1'b1;
    end
    if (is_start && (state_q != ST_IDLE)) begin
      pending_d[ERR_BIT_START] = 1'b1;
    end
    if (is_invalid) begin
      pending_d[ERR_BIT_INVALID] = 1'b1;
    end

    job_ea_d     = ((state_q == ST_IDLE) && is_start) ? ha_jea : job_ea_q;
    core_start_d = (state_q == ST_IDLE) && is_start;
    core_reset_d = (state_d == ST_RESETTING);

    // LLCMDs seen while busy are held until DONE hands back to IDLE.
    ll_now    = is_llcmd && ((state_q == ST_IDLE) || (state_q == ST_RUNNING));
    ll_defer  = is_llcmd && ((state_q == ST_RESETTING) || (state_q == ST_DONE));
    done_exit = (state_q == ST_DONE) && (state_d == ST_IDLE);
    jcack_d   = ll_now || (done_exit && (llpend_q || ll_defer));
    llpend_d  = done_exit ? 1'b0 : (llpend_q || ll_defer);
  end

  always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
    if (!ha_preset_n) begin
      pending_q    <= '0;
      job_ea_q     <= '0;
      core_reset_q <= 1'b1;
      core_start_q <= 1'b0;
      jcack_q      <= 1'b0;
      llpend_q     <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      job_ea_q     <= job_ea_d;
      core_reset_q <= core_reset_d;
      core_start_q <= core_start_d;
      jcack_q      <= jcack_d;
      llpend_q     <= llpend_d;
    end
  end

  // Output logic
  always_comb begin
    core_reset  = core_reset_q;
    core_start  = core_start_q;
    job_ea      = job_ea_q;
    ah_jrunning = (state_q == ST_RUNNING);
    ah_jdone    = (state_q == ST_DONE);
    ah_jerror   = (state_q == ST_DONE) ? pending_q : '0;
    ah_jcack    = jcack_q;
    ah_jyield   = 1'b0;
  end

endmodule
